// File: rtl/alu_pkg.sv
// Shared encodings for the ALU arbiter slice: ALU operation codes,
// ZERO-flag condition selects and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALUOP_AND  = 4'b0000;
    localparam logic [3:0] ALUOP_OR   = 4'b0001;
    localparam logic [3:0] ALUOP_ADD  = 4'b0010;
    localparam logic [3:0] ALUOP_SUB  = 4'b0110;
    localparam logic [3:0] ALUOP_NOR  = 4'b1100;
    localparam logic [3:0] ALUOP_SLLI = 4'b1000;

    localparam logic [2:0] F3_EQZ = 3'b000;
    localparam logic [2:0] F3_NEG = 3'b100;
    localparam logic [2:0] F3_POS = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ALU_64_bit.sv
// Combinational 64-bit ALU with a funct3-selected ZERO condition.
// Unknown opcodes yield zero; shifts use the full 64-bit amount.
module ALU_64_bit
    import alu_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  aluop,
    input  logic [2:0]  funct3,
    output logic [63:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (aluop)
            ALUOP_AND:  result = a & b;
            ALUOP_OR:   result = a | b;
            ALUOP_ADD:  result = a + b;
            ALUOP_SUB:  result = a - b;
            ALUOP_NOR:  result = ~(a | b);
            ALUOP_SLLI: result = a << b;
            default:    result = '0;
        endcase
    end

    always_comb begin
        zero = 1'b0;
        case (funct3)
            F3_EQZ:  zero = (result == 64'd0);
            F3_NEG:  zero = result[63];
            F3_POS:  zero = ~result[63];
            default: zero = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared 64-bit ALU: accepts one
// operation at a time, executes it from registered operands, returns a registered result.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][63:0] req_a,
    input  logic [1:0][63:0] req_b,
    input  logic [1:0][3:0]  req_aluop,
    input  logic [1:0][2:0]  req_funct3,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [63:0]      rsp_result,
    output logic             rsp_zero,
    output logic             busy,
    output logic             owner,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, ready may depend on valid.
    state_t      state_q, state_d;
    logic        last_grant;
    logic        winner;
    logic [63:0] op_a, op_b;
    logic [3:0]  op_aluop;
    logic [2:0]  op_funct3;
    logic [63:0] alu_result;
    logic        alu_zero;

    ALU_64_bit u_alu (
        .a      (op_a),
        .b      (op_b),
        .aluop  (op_aluop),
        .funct3 (op_funct3),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // A lone requester always wins; on a tie the one not served last wins.
    assign winner    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        req_ready[winner] = 1'b1;
                        state_d           = EXEC;
                    end
                end
                EXEC: state_d = RESP;
                RESP: begin
                    rsp_valid[owner] = 1'b1;
                    if (rsp_ready[owner]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_aluop   <= '0;
            op_funct3  <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        op_a      <= req_a[winner];
                        op_b      <= req_b[winner];
                        op_aluop  <= req_aluop[winner];
                        op_funct3 <= req_funct3[winner];
                        owner     <= winner;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        last_grant <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: drivers per requester, an accept-side
// monitor filling the expected queue, and a response-side scoreboard.
module tb_alu_arbiter;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLLI = 4'b1000;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][63:0] req_a;
    logic [1:0][63:0] req_b;
    logic [1:0][3:0]  req_aluop;
    logic [1:0][2:0]  req_funct3;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [63:0]      rsp_result;
    logic             rsp_zero;
    logic             busy;
    logic             owner;
    logic [1:0]       dbg_state;

    logic [65:0] exp_q[$];
    logic        grant_log[$];
    int          grant_cyc[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_aluop  (req_aluop),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy),
        .owner      (owner),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ALU: {zero, result}
    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] op, input logic [2:0] f3);
        logic [63:0] r;
        logic        z;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b1100: r = ~(a | b);
            4'b1000: r = (b > 64'd63) ? 64'd0 : (a << b[5:0]);
            default: r = 64'd0;
        endcase
        case (f3)
            3'b000:  z = (r == 64'd0);
            3'b100:  z = r[63];
            3'b101:  z = ~r[63];
            default: z = 1'b0;
        endcase
        return {z, r};
    endfunction

    // Accept side: every request handshake produces one expected response.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                exp_q.push_back({k[0], model(req_a[k], req_b[k], req_aluop[k], req_funct3[k])});
                grant_log.push_back(k[0]);
                grant_cyc.push_back(cyc);
            end
        end
    end

    // Response side: scoreboard pops on each response handshake.
    logic [65:0] mon_e;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rsp_valid[k] && rsp_ready[k]) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_requester", 64'(k), 64'(mon_e[65]));
                    check("rsp_result", rsp_result, mon_e[63:0]);
                    check("rsp_zero", 64'(rsp_zero), 64'(mon_e[64]));
                    check("rsp_other_valid", 64'(rsp_valid[1-k]), 64'd0);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op, input logic [2:0] f3);
        int n = 0;
        @(posedge clk);
        #1;
        req_a[i] = a;
        req_b[i] = b;
        req_aluop[i] = op;
        req_funct3[i] = f3;
        req_valid[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 60);
        if (!req_ready[i]) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_valid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        @(negedge clk);
        check("exec_busy", 64'(busy), 64'd1);
        check("exec_owner", 64'(owner), 64'(i));
        check("exec_rsp_valid", 64'(rsp_valid[i]), 64'd0);
        @(negedge clk);
        check("resp_latency", 64'(rsp_valid[i]), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_result"}, rsp_result, 64'd0);
        check({tag, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_owner"}, 64'(owner), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [64:0] tmp;
    logic [3:0]  op_tab [7];
    logic [2:0]  f3_tab [4];

    initial begin
        op_tab = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLLI, 4'b0011};
        f3_tab = '{3'b000, 3'b100, 3'b101, 3'b010};
        reset = 1'b1;
        req_valid = 2'b01;
        req_a = '0;
        req_b = '0;
        req_aluop = '0;
        req_funct3 = '0;
        rsp_ready = 2'b11;

        // Reset with a pending request: reset wins the handshake.
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check_reset_outputs("reset");
        req_valid = 2'b00;
        @(posedge clk);
        #1 reset = 1'b0;

        // Single operations from each requester.
        send(0, 64'd5, 64'd7, OP_ADD, 3'b000);
        send(1, 64'd9, 64'd9, OP_SUB, 3'b000);
        drain();

        // Ties from reset alternate 0,1,0,1 and each grant is 3 cycles apart.
        apply_reset();
        grant_log.delete();
        grant_cyc.delete();
        fork
            begin
                send(0, 64'd1, 64'd1, OP_ADD, 3'b000);
                send(0, 64'd20, 64'd22, OP_ADD, 3'b000);
            end
            begin
                send(1, 64'd1, 64'd4, OP_SLLI, 3'b000);
                send(1, 64'hF0, 64'h0F, OP_OR, 3'b000);
            end
        join
        drain();
        check("tie_grant_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            check("tie_grant0", 64'(grant_log[0]), 64'd0);
            check("tie_grant1", 64'(grant_log[1]), 64'd1);
            check("tie_grant2", 64'(grant_log[2]), 64'd0);
            check("tie_grant3", 64'(grant_log[3]), 64'd1);
            for (int j = 1; j < 4; j++)
                check("tie_spacing", 64'(grant_cyc[j] - grant_cyc[j-1]), 64'd3);
        end

        // Lone requester that was served last is not starved.
        grant_cyc.delete();
        for (int j = 0; j < 3; j++)
            send(1, 64'(j + 100), 64'd1, OP_ADD, 3'b101);
        drain();
        check("lone_count", 64'(grant_cyc.size()), 64'd3);
        if (grant_cyc.size() == 3) begin
            check("lone_spacing0", 64'(grant_cyc[1] - grant_cyc[0]), 64'd3);
            check("lone_spacing1", 64'(grant_cyc[2] - grant_cyc[1]), 64'd3);
        end

        // Backpressure on requester 0 while requester 1 waits.
        rsp_ready[0] = 1'b0;
        send(0, 64'h1234, 64'h00F0, OP_OR, 3'b000);
        tmp = model(64'h1234, 64'h00F0, OP_OR, 3'b000);
        fork
            send(1, 64'd50, 64'd8, OP_SUB, 3'b100);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
                    check("bp_busy", 64'(busy), 64'd1);
                    check("bp_req_ready1", 64'(req_ready[1]), 64'd0);
                    check("bp_result", rsp_result, tmp[63:0]);
                end
                @(posedge clk);
                #1 rsp_ready[0] = 1'b1;
            end
        join
        drain();

        // Edge opcodes and ZERO conditions.
        send(0, 64'd0, 64'd1, OP_SUB, 3'b100);
        send(1, 64'd5, 64'd6, 4'b1111, 3'b000);
        send(0, 64'd0, 64'd0, OP_ADD, 3'b010);
        send(1, 64'd1, 64'd70, OP_SLLI, 3'b000);
        send(0, 64'd0, 64'd0, OP_NOR, 3'b101);
        send(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 3'b000);
        repeat (8) begin
            automatic logic [3:0]  rop = op_tab[$urandom_range(0, 6)];
            automatic logic [63:0] ra  = {$urandom, $urandom};
            automatic logic [63:0] rb  = (rop == OP_SLLI) ? 64'($urandom_range(0, 63))
                                                         : {$urandom, $urandom};
            send($urandom_range(0, 1), ra, rb, rop, f3_tab[$urandom_range(0, 3)]);
        end
        drain();

        // Reset while an operation is in EXEC discards it.
        @(posedge clk);
        #1;
        req_a[1] = 64'd100;
        req_b[1] = 64'd23;
        req_aluop[1] = OP_ADD;
        req_funct3[1] = 3'b101;
        req_valid[1] = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!req_ready[1] && n < 60);
            check("rst_exec_accept", 64'(req_ready[1]), 64'd1);
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_exec_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        @(negedge clk);
        check_reset_outputs("rst_exec");
        repeat (3) begin
            @(negedge clk);
            check("rst_exec_no_rsp", 64'(rsp_valid), 64'd0);
        end
        send(0, 64'd3, 64'd4, OP_ADD, 3'b000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
